texture_quad_memory: RTL and testbench
======================================

Name: texture_quad_memory

Overview:
- Texel store on the responder side of the TMU texel-quad interface: serves four independent texel reads per cycle (addr00/01/10/11 -> texel00/01/10/11).
- Loaded from a streaming upload port driven by the command/DMA path.
- Sits between the texture upload stream and one TextureMappingUnit instance; one instance per TMU.

Parameters:
- PIXEL_WIDTH, 32, texel width in bits (4 x SUB_PIXEL_WIDTH).
- ADDR_WIDTH, 17, texel word address width; depth = 2**ADDR_WIDTH words.
- STREAM_WIDTH, 64, upload beat width; must be an integer multiple N of PIXEL_WIDTH (N = STREAM_WIDTH / PIXEL_WIDTH, N in {1, 2, 4}).

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- texelAddr00  in  ADDR_WIDTH  quad read address, top-left
- texelAddr01  in  ADDR_WIDTH  quad read address, top-right
- texelAddr10  in  ADDR_WIDTH  quad read address, bottom-left
- texelAddr11  in  ADDR_WIDTH  quad read address, bottom-right
- texelOutput00  out  PIXEL_WIDTH  texel for texelAddr00
- texelOutput01  out  PIXEL_WIDTH  texel for texelAddr01
- texelOutput10  out  PIXEL_WIDTH  texel for texelAddr10
- texelOutput11  out  PIXEL_WIDTH  texel for texelAddr11
- loadStart  in  1  single-cycle pulse, begin upload
- loadBaseAddr  in  ADDR_WIDTH  first texel address of upload; sampled with loadStart
- loadBusy  out  1  upload in progress
- loadDone  out  1  single-cycle pulse when upload completes
- loadOverflow  out  1  sticky: beats were discarded past the end of memory; cleared by loadStart
- s_axis_tvalid  in  1  upload beat valid
- s_axis_tready  out  1  upload beat ready
- s_axis_tdata  in  STREAM_WIDTH  N texels; lowest PIXEL_WIDTH slice is at the lowest address
- s_axis_tlast  in  1  last beat of upload

Behaviour:
- Clocking and reset: one clock, aclk; resetn is asynchronous, active-low.
- Reset values: texelOutputXX = 0, s_axis_tready = 0, loadBusy = 0, loadDone = 0, loadOverflow = 0, FSM = IDLE.
- Reset does not clear memory contents.
- Read path:
  - Four identical replicated RAM copies. Every write goes to all four; read port k reads copy k.
  - Latency is exactly 1 cycle: texelOutputXX at edge n+1 = mem[texelAddrXX sampled at edge n].
  - No read enable. Outputs track addresses every cycle, so a stalled consumer holds its addresses.
  - Read and write to the same address in the same cycle returns the old data (read-first).
  - Reads are permitted during an upload and return current contents.
- Upload FSM:
  - IDLE:
    - s_axis_tready = 0.
    - On loadStart: wrAddr <= loadBaseAddr; loadOverflow <= 0; go to LOAD.
  - LOAD:
    - s_axis_tready = 1; loadBusy = 1.
    - Each accepted beat writes slice i to wrAddr+i for i = 0..N-1, then wrAddr += N.
    - Any slice whose address would exceed 2**ADDR_WIDTH-1 is not written (no wrap-around) and sets loadOverflow.
    - Once wrAddr passes the end: remaining beats are accepted and discarded while staying in LOAD.
    - Accepted beat with tlast=1 -> DONE.
  - DONE:
    - s_axis_tready = 0; loadBusy = 1.
    - loadDone = 1 for exactly this cycle; next state IDLE.
- Edge cases:
  - loadStart while in LOAD or DONE is ignored.
  - loadStart and a beat in the same IDLE cycle: the beat is not accepted (tready = 0).
  - tvalid without a prior loadStart: held off indefinitely.
- Address arithmetic:
  - wrAddr is ADDR_WIDTH+1 bits wide, so the end-of-memory comparison cannot alias.
  - Read addresses are used unmodified; the full ADDR_WIDTH range is valid.
- Reset mid-upload: FSM returns to IDLE. Words already written remain; the partial upload is not rolled back.

Test Plan:
- Upload, N=2: loadStart with base 0x00010, then 3 beats {0x22222222_11111111}, {0x44444444_33333333}, {0x66666666_55555555}, tlast on the 3rd.
  - loadDone pulses 1 cycle after the 3rd beat.
  - Reading addr 0x10..0x15 returns 0x11111111..0x66666666 one cycle after the address is applied.
- Quad read: after the upload above, present addr00=0x10, 01=0x11, 10=0x14, 11=0x15 in one cycle.
  - Next cycle outputs are 0x11111111, 0x22222222, 0x55555555, 0x66666666.
  - Change the addresses each cycle for 8 cycles; each output lags its address by exactly 1 cycle.
- Backpressure: tvalid toggles 1,0,1,1,0,1 with tlast on the 4th valid beat.
  - Exactly 4 beats are written at consecutive addresses.
  - tready falls in the DONE cycle; loadDone fires once.
- Overflow: base 0x1FFFF, N=2, 2 beats.
  - Only 0x1FFFF is written; loadOverflow = 1; addr 0x00000 is unchanged.
  - Both beats are still accepted; loadDone fires.
  - The next loadStart clears loadOverflow.
- Read/write collision: read addr 0x20 while the beat writing 0x20 (old 0xAAAAAAAA, new 0xBBBBBBBB) is accepted.
  - The output shows 0xAAAAAAAA; the following cycle shows 0xBBBBBBBB.
- Reset mid-upload: assert resetn=0 after 1 of 3 beats.
  - Outputs, tready, loadBusy and loadDone go to 0 immediately (asynchronous).
  - After release the FSM is IDLE and tvalid is held off until the next loadStart.

Source files
------------

// File: rtl/texture_quad_memory.sv
// Quad-ported texel store for one TMU: four replicated RAM copies, one per read port,
// loaded through an AXI-stream upload port with end-of-memory clipping.
module texture_quad_memory #(
  parameter int PIXEL_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 17,
  parameter int STREAM_WIDTH = 64
) (
  input  logic                    aclk,
  input  logic                    resetn,

  input  logic [ADDR_WIDTH-1:0]   texelAddr00,
  input  logic [ADDR_WIDTH-1:0]   texelAddr01,
  input  logic [ADDR_WIDTH-1:0]   texelAddr10,
  input  logic [ADDR_WIDTH-1:0]   texelAddr11,
  output logic [PIXEL_WIDTH-1:0]  texelOutput00,
  output logic [PIXEL_WIDTH-1:0]  texelOutput01,
  output logic [PIXEL_WIDTH-1:0]  texelOutput10,
  output logic [PIXEL_WIDTH-1:0]  texelOutput11,

  input  logic                    loadStart,
  input  logic [ADDR_WIDTH-1:0]   loadBaseAddr,
  output logic                    loadBusy,
  output logic                    loadDone,
  output logic                    loadOverflow,

  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tlast
);

  // state | meaning
  // IDLE  | waiting for loadStart, stream held off
  // LOAD  | accepting beats, writing N texels per beat
  // DONE  | one-cycle completion pulse, stream held off
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam int N     = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] STEP      = (ADDR_WIDTH + 1)'(N);

  state_t                  state;
  logic [ADDR_WIDTH:0]     wr_addr;
  logic                    beat_fire;
  logic                    slice_drop;
  logic [N-1:0]            slice_en;
  logic [ADDR_WIDTH:0]     slice_full [N];
  logic [ADDR_WIDTH-1:0]   slice_addr [N];
  logic [PIXEL_WIDTH-1:0]  slice_data [N];
  logic [ADDR_WIDTH-1:0]   rd_addr [4];

  assign beat_fire = s_axis_tready && s_axis_tvalid;

  // wr_addr carries one extra bit so slices past the top never alias onto low memory.
  always_comb begin
    slice_drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      slice_full[i] = wr_addr + (ADDR_WIDTH + 1)'(i);
      slice_addr[i] = slice_full[i][ADDR_WIDTH-1:0];
      slice_data[i] = s_axis_tdata[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      slice_en[i]   = beat_fire && (slice_full[i] <= LAST_ADDR);
      if (beat_fire && (slice_full[i] > LAST_ADDR)) begin
        slice_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      wr_addr       <= '0;
      s_axis_tready <= 1'b0;
      loadBusy      <= 1'b0;
      loadDone      <= 1'b0;
      loadOverflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          loadDone <= 1'b0;
          if (loadStart) begin
            wr_addr       <= {1'b0, loadBaseAddr};
            loadOverflow  <= 1'b0;
            s_axis_tready <= 1'b1;
            loadBusy      <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (beat_fire) begin
            // Saturate once past the end so the pointer cannot wrap back into range.
            if (wr_addr <= LAST_ADDR) begin
              wr_addr <= wr_addr + STEP;
            end
            if (slice_drop) begin
              loadOverflow <= 1'b1;
            end
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              loadDone      <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          loadDone <= 1'b0;
          loadBusy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          s_axis_tready <= 1'b0;
          loadBusy      <= 1'b0;
          loadDone      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr[0] = texelAddr00;
  assign rd_addr[1] = texelAddr01;
  assign rd_addr[2] = texelAddr10;
  assign rd_addr[3] = texelAddr11;

  // One full copy per read port; the read register samples before the same-edge write lands.
  for (genvar k = 0; k < 4; k++) begin : g_copy
    logic [PIXEL_WIDTH-1:0] mem [DEPTH];
    logic [PIXEL_WIDTH-1:0] rd_q;

    always_ff @(posedge aclk) begin
      for (int i = 0; i < N; i++) begin
        if (slice_en[i]) begin
          mem[slice_addr[i]] <= slice_data[i];
        end
      end
    end

    always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
        rd_q <= '0;
      end else begin
        rd_q <= mem[rd_addr[k]];
      end
    end
  end

  assign texelOutput00 = g_copy[0].rd_q;
  assign texelOutput01 = g_copy[1].rd_q;
  assign texelOutput10 = g_copy[2].rd_q;
  assign texelOutput11 = g_copy[3].rd_q;

endmodule

// File: tb/tb_texture_quad_memory.sv
// Randomized bench for texture_quad_memory against an associative-array memory model.
module tb_texture_quad_memory;

  localparam int PW   = 32;
  localparam int AW   = 17;
  localparam int SW   = 64;
  localparam int N    = SW / PW;
  localparam int LAST = (1 << AW) - 1;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] texelAddr00 = '0, texelAddr01 = '0, texelAddr10 = '0, texelAddr11 = '0;
  logic [PW-1:0] texelOutput00, texelOutput01, texelOutput10, texelOutput11;
  logic          loadStart = 1'b0;
  logic [AW-1:0] loadBaseAddr = '0;
  logic          loadBusy, loadDone, loadOverflow;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [SW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;

  always #5 aclk = ~aclk;

  texture_quad_memory #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .STREAM_WIDTH(SW)) dut (
    .aclk(aclk), .resetn(resetn),
    .texelAddr00(texelAddr00), .texelAddr01(texelAddr01),
    .texelAddr10(texelAddr10), .texelAddr11(texelAddr11),
    .texelOutput00(texelOutput00), .texelOutput01(texelOutput01),
    .texelOutput10(texelOutput10), .texelOutput11(texelOutput11),
    .loadStart(loadStart), .loadBaseAddr(loadBaseAddr),
    .loadBusy(loadBusy), .loadDone(loadDone), .loadOverflow(loadOverflow),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: what each address holds, plus the upload phase after the coming edge.
  logic [31:0] ref_mem [int];
  int          known_q[$];
  int          m_phase = 0;   // 0 idle, 1 loading, 2 finishing
  longint      m_wptr  = 0;
  bit          m_ovf   = 0;
  int          done_seen = 0;
  logic [63:0] beats[$];

  function automatic int pick_addr();
    if (known_q.size() > 0 && $urandom_range(3) != 0)
      return known_q[$urandom_range(known_q.size() - 1)];
    return int'($urandom_range(LAST));
  endfunction

  task automatic rand_reads();
    texelAddr00 = AW'(pick_addr());
    texelAddr01 = AW'(pick_addr());
    texelAddr10 = AW'(pick_addr());
    texelAddr11 = AW'(pick_addr());
  endtask

  task automatic tick();
    int          a[4];
    bit          kn[4];
    logic [31:0] exp_rd[4];
    logic [31:0] obs[4];
    logic [63:0] d;
    longint      wa;
    a[0] = int'(texelAddr00); a[1] = int'(texelAddr01);
    a[2] = int'(texelAddr10); a[3] = int'(texelAddr11);
    for (int k = 0; k < 4; k++) begin
      kn[k] = ref_mem.exists(a[k]);
      exp_rd[k] = kn[k] ? ref_mem[a[k]] : 32'h0;
    end
    if (m_phase == 1) begin
      if (s_axis_tvalid) begin
        d = s_axis_tdata;
        for (int i = 0; i < N; i++) begin
          wa = m_wptr + i;
          if (wa <= LAST) begin
            if (!ref_mem.exists(int'(wa))) known_q.push_back(int'(wa));
            ref_mem[int'(wa)] = d[i*PW +: PW];
          end else begin
            m_ovf = 1;
          end
        end
        m_wptr += N;
        if (s_axis_tlast) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (loadStart) begin
      m_wptr  = longint'(loadBaseAddr);
      m_ovf   = 0;
      m_phase = 1;
    end
    @(posedge aclk);
    #1;
    obs[0] = texelOutput00; obs[1] = texelOutput01;
    obs[2] = texelOutput10; obs[3] = texelOutput11;
    for (int k = 0; k < 4; k++)
      if (kn[k]) check_val($sformatf("rd%0d@%0h", k, a[k]), 64'(obs[k]), 64'(exp_rd[k]));
    check_val("tready", 64'(s_axis_tready), 64'(m_phase == 1));
    check_val("busy",   64'(loadBusy),      64'(m_phase != 0));
    check_val("done",   64'(loadDone),      64'(m_phase == 2));
    check_val("ovf",    64'(loadOverflow),  64'(m_ovf));
    if (loadDone) done_seen++;
  endtask

  task automatic run_upload(input int base, input int nbeats, input int gap_pct);
    int sent = 0;
    int guard = 0;
    loadStart = 1'b1;
    loadBaseAddr = AW'(base);
    s_axis_tvalid = 1'($urandom_range(1));
    s_axis_tdata = {$urandom, $urandom};
    s_axis_tlast = 1'b0;
    rand_reads();
    tick();
    while (sent < nbeats && guard < 1000) begin
      s_axis_tvalid = ($urandom_range(99) >= gap_pct);
      s_axis_tdata  = (beats.size() > sent) ? beats[sent] : {$urandom, $urandom};
      s_axis_tlast  = (sent == nbeats - 1);
      loadStart     = ($urandom_range(7) == 0);
      loadBaseAddr  = AW'($urandom_range(LAST));
      rand_reads();
      tick();
      if (s_axis_tvalid) sent++;
      guard++;
    end
    check_val("upl_guard", 64'(guard < 1000), 64'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    loadStart     = 1'b0;
    rand_reads();
    tick();
    rand_reads();
    tick();
    beats.delete();
  endtask

  initial begin
    logic [31:0] exp32;
    int          dn0;
    bit          pat[6];

    #3;
    check_val("rst_o00", 64'(texelOutput00), 64'd0);
    check_val("rst_o01", 64'(texelOutput01), 64'd0);
    check_val("rst_o10", 64'(texelOutput10), 64'd0);
    check_val("rst_o11", 64'(texelOutput11), 64'd0);
    check_val("rst_tready", 64'(s_axis_tready), 64'd0);
    check_val("rst_busy", 64'(loadBusy), 64'd0);
    check_val("rst_done", 64'(loadDone), 64'd0);
    check_val("rst_ovf", 64'(loadOverflow), 64'd0);
    @(posedge aclk);
    #1;
    resetn = 1'b1;

    // Low memory becomes known so the overflow case can show address 0 untouched.
    run_upload(0, 4, 0);

    beats = {64'h22222222_11111111, 64'h44444444_33333333, 64'h66666666_55555555};
    dn0 = done_seen;
    run_upload(32'h10, 3, 0);
    check_val("upl_done_cnt", 64'(done_seen - dn0), 64'd1);
    for (int j = 0; j < 6; j++) begin
      rand_reads();
      texelAddr00 = AW'(32'h10 + j);
      tick();
      exp32 = 32'h11111111 * (j + 1);
      check_val("upl_rd", 64'(texelOutput00), 64'(exp32));
    end

    texelAddr00 = AW'(32'h10); texelAddr01 = AW'(32'h11);
    texelAddr10 = AW'(32'h14); texelAddr11 = AW'(32'h15);
    tick();
    check_val("quad00", 64'(texelOutput00), 64'h11111111);
    check_val("quad01", 64'(texelOutput01), 64'h22222222);
    check_val("quad10", 64'(texelOutput10), 64'h55555555);
    check_val("quad11", 64'(texelOutput11), 64'h66666666);
    repeat (8) begin
      rand_reads();
      tick();
    end

    // Backpressure: valid 1,0,1,1,0,1 with tlast on the fourth valid beat.
    pat = '{1, 0, 1, 1, 0, 1};
    dn0 = done_seen;
    loadStart = 1'b1; loadBaseAddr = AW'(32'h40);
    rand_reads();
    tick();
    loadStart = 1'b0;
    begin
      int nv = 0;
      for (int j = 0; j < 6; j++) begin
        s_axis_tvalid = pat[j];
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tlast  = pat[j] && (nv == 3);
        rand_reads();
        tick();
        if (pat[j]) nv++;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    rand_reads();
    tick();
    rand_reads();
    tick();
    check_val("bp_done_cnt", 64'(done_seen - dn0), 64'd1);
    for (int j = 0; j < 8; j++) begin
      rand_reads();
      texelAddr00 = AW'(32'h40 + j);
      tick();
    end

    // Overflow at the top of memory.
    dn0 = done_seen;
    run_upload(LAST, 2, 0);
    check_val("ovf_sticky", 64'(loadOverflow), 64'd1);
    check_val("ovf_done_cnt", 64'(done_seen - dn0), 64'd1);
    texelAddr00 = '0; texelAddr01 = AW'(LAST); texelAddr10 = AW'(1); texelAddr11 = AW'(LAST);
    tick();
    tick();
    run_upload(32'h50, 2, 20);
    check_val("ovf_cleared", 64'(loadOverflow), 64'd0);

    // Read-first collision on 0x20.
    beats = {64'h12345678_AAAAAAAA};
    run_upload(32'h20, 1, 0);
    loadStart = 1'b1; loadBaseAddr = AW'(32'h20);
    texelAddr00 = AW'(32'h20);
    tick();
    loadStart = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 64'h87654321_BBBBBBBB; s_axis_tlast = 1'b1;
    tick();
    check_val("coll_old", 64'(texelOutput00), 64'hAAAAAAAA);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tick();
    check_val("coll_new", 64'(texelOutput00), 64'hBBBBBBBB);

    for (int r = 0; r < 6; r++) begin
      int base;
      base = (r % 2 == 0) ? int'($urandom_range(LAST)) : LAST - int'($urandom_range(6));
      run_upload(base, int'($urandom_range(1, 8)), 30);
    end

    // Asynchronous reset part way through an upload.
    loadStart = 1'b1; loadBaseAddr = AW'(32'h300);
    rand_reads();
    tick();
    loadStart = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = {$urandom, $urandom}; s_axis_tlast = 1'b0;
    tick();
    #2;
    resetn = 1'b0;
    #1;
    m_phase = 0;
    m_ovf   = 0;
    check_val("mrst_o00", 64'(texelOutput00), 64'd0);
    check_val("mrst_o11", 64'(texelOutput11), 64'd0);
    check_val("mrst_tready", 64'(s_axis_tready), 64'd0);
    check_val("mrst_busy", 64'(loadBusy), 64'd0);
    check_val("mrst_done", 64'(loadDone), 64'd0);
    @(posedge aclk);
    #1;
    resetn = 1'b1;
    repeat (5) begin
      s_axis_tdata = {$urandom, $urandom};
      texelAddr00 = AW'(32'h300); texelAddr01 = AW'(32'h301);
      texelAddr10 = AW'(32'h302); texelAddr11 = AW'(32'h303);
      tick();
    end
    s_axis_tvalid = 1'b0;
    run_upload(32'h302, 2, 0);
    repeat (10) begin
      rand_reads();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
